// File: rtl/fbindct_bram_wb.sv
// Purpose : binDCT write-back. Captures coefficient rows, splits each into BRAM words and
//           writes them into output partition A or B. Toggles ps_irq when a partition is full.
// Latency : word 0 of a row is written in the cycle after capture, then one word per cycle.
// Backpressure: wb_ready is low while a row cannot be taken. A row offered while wb_ready is
//           low is dropped and sets the sticky wb_error.
// Optional feature: FBINDCT_WB_SKID_EN adds a one-row skid register so rows can arrive
//           back-to-back at one row per WPR cycles.
//
// Ports:
//   clk, rst               sole clock (rising edge) and synchronous active-high reset
//   wb_start, wb_partition arm a block; partition 0 = A (OUT_BASE), 1 = B (OUT_BASE+DATA_DEPTH)
//   dct_valid, dct_coef    row strobe and row; coefficient k is at [k*OUT_WIDTH +: OUT_WIDTH]
//   wb_ready               a row is accepted this cycle
//   bram_addr/wrdata/en/we BRAM write port; all outputs are registered
//   ps_irq                 toggles once per completed partition
//   wb_error               sticky; a row arrived while wb_ready was low
module fbindct_bram_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_DEPTH = 512,
    parameter int OUT_BASE   = 1024,
    parameter int ROW_DIM    = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wb_start,
    input  logic                           wb_partition,
    input  logic                           dct_valid,
    input  logic [ROW_DIM*OUT_WIDTH-1:0]   dct_coef,
    output logic                           wb_ready,
    output logic [ADDR_WIDTH-1:0]          bram_addr,
    output logic [DATA_WIDTH-1:0]          bram_wrdata,
    output logic                           bram_en,
    output logic                           bram_we,
    output logic                           ps_irq,
    output logic                           wb_error
);

    localparam int ROW_W = ROW_DIM * OUT_WIDTH;
    localparam int WPR   = ROW_W / DATA_WIDTH;
    localparam int ROWS  = DATA_DEPTH / WPR;
    localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [WW-1:0]         WLAST  = WW'(WPR - 1);
    localparam logic [RW-1:0]         RLAST  = RW'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(OUT_BASE);
    localparam logic [ADDR_WIDTH-1:0] BASE_B = ADDR_WIDTH'(OUT_BASE + DATA_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WPR_A  = ADDR_WIDTH'(WPR);

    typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE} state_t;

    state_t                  state_q;
    logic                    part_q;
    logic [RW-1:0]           row_q;
    logic [WW-1:0]           word_q;
    logic [ROW_W-1:0]        rowreg_q;
    logic                    ready_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wrdata_q;
    logic                    en_q;
    logic                    irq_q;
    logic                    err_q;

    logic [WW-1:0]           word_nx_d;
    logic [RW-1:0]           row_nx_d;

`ifdef FBINDCT_WB_SKID_EN
    logic [ROW_W-1:0]        skid_q;
    logic                    skid_vld_q;
`endif

    always_comb begin
        word_nx_d = word_q + 1'b1;
        row_nx_d  = row_q + 1'b1;
    end

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic p,
                                                        input logic [RW-1:0] r,
                                                        input logic [WW-1:0] w);
        return (p ? BASE_B : BASE_A) + ADDR_WIDTH'(r) * WPR_A + ADDR_WIDTH'(w);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            part_q   <= 1'b0;
            row_q    <= '0;
            word_q   <= '0;
            rowreg_q <= '0;
            ready_q  <= 1'b0;
            addr_q   <= '0;
            wrdata_q <= '0;
            en_q     <= 1'b0;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef FBINDCT_WB_SKID_EN
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
`endif
        end else begin
            en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wb_start) begin
                        part_q  <= wb_partition;
                        row_q   <= '0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (dct_valid) begin
                        rowreg_q <= dct_coef;
                        word_q   <= '0;
                        en_q     <= 1'b1;
                        addr_q   <= word_addr(part_q, row_q, '0);
                        wrdata_q <= dct_coef[DATA_WIDTH-1:0];
`ifdef FBINDCT_WB_SKID_EN
                        // The last row of a partition must never leave a row in the skid.
                        ready_q  <= (row_q != RLAST);
`else
                        ready_q  <= 1'b0;
`endif
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    if (word_q != WLAST) begin
                        word_q   <= word_nx_d;
                        en_q     <= 1'b1;
                        addr_q   <= word_addr(part_q, row_q, word_nx_d);
                        wrdata_q <= rowreg_q[int'(word_nx_d)*DATA_WIDTH +: DATA_WIDTH];
`ifdef FBINDCT_WB_SKID_EN
                        if (dct_valid && ready_q) begin
                            skid_q     <= dct_coef;
                            skid_vld_q <= 1'b1;
                            ready_q    <= 1'b0;
                        end
`endif
                    end else if (row_q == RLAST) begin
                        ready_q <= 1'b0;
                        irq_q   <= ~irq_q;
                        state_q <= DONE;
                    end else begin
                        row_q <= row_nx_d;
`ifdef FBINDCT_WB_SKID_EN
                        // Chain the next row without a gap: from the skid if it holds one,
                        // otherwise straight from the input when a row arrives this cycle.
                        if (skid_vld_q || (dct_valid && ready_q)) begin
                            rowreg_q   <= skid_vld_q ? skid_q : dct_coef;
                            wrdata_q   <= skid_vld_q ? skid_q[DATA_WIDTH-1:0]
                                                     : dct_coef[DATA_WIDTH-1:0];
                            skid_vld_q <= 1'b0;
                            word_q     <= '0;
                            en_q       <= 1'b1;
                            addr_q     <= word_addr(part_q, row_nx_d, '0);
                            ready_q    <= (row_nx_d != RLAST);
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= ARMED;
                        end
`else
                        ready_q <= 1'b1;
                        state_q <= ARMED;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
            // Placed after the case so a dropped row in the same cycle as wb_start still
            // leaves the error flag set.
            if (dct_valid && !ready_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign wb_ready    = ready_q;
    assign bram_addr   = addr_q;
    assign bram_wrdata = wrdata_q;
    assign bram_en     = en_q;
    assign bram_we     = en_q;
    assign ps_irq      = irq_q;
    assign wb_error    = err_q;

endmodule

// File: tb/tb_fbindct_bram_wb.sv
module tb_fbindct_bram_wb;

`ifdef FBINDCT_WB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wb_start = 1'b0;
    logic         wb_partition = 1'b0;
    logic         dct_valid = 1'b0;
    logic [127:0] dct_coef = '0;
    logic         wb_ready;
    logic [12:0]  bram_addr;
    logic [31:0]  bram_wrdata;
    logic         bram_en;
    logic         bram_we;
    logic         ps_irq;
    logic         wb_error;

    fbindct_bram_wb dut (
        .clk(clk), .rst(rst), .wb_start(wb_start), .wb_partition(wb_partition),
        .dct_valid(dct_valid), .dct_coef(dct_coef), .wb_ready(wb_ready),
        .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_en(bram_en),
        .bram_we(bram_we), .ps_irq(ps_irq), .wb_error(wb_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] a;
        logic [31:0] d;
        bit          last;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor / scoreboard: compares every BRAM write against the queue and tracks the
    // cycle in which ps_irq must toggle (one cycle after the last write of a partition).
    logic exp_irq = 1'b0;
    bit   irq_pend = 1'b0;
    logic rst_prev = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        if (rst_prev) begin
            exp_irq  = 1'b0;
            irq_pend = 1'b0;
        end else begin
            if (irq_pend) begin
                exp_irq  = ~exp_irq;
                irq_pend = 1'b0;
            end
            chk("ps_irq", 64'(ps_irq), 64'(exp_irq));
        end
        if (bram_we && !bram_en) chk("we_without_en", 64'(bram_en), 64'd1);
        if (bram_en && bram_we) begin
            if (expq.size() == 0) begin
                chk("unexpected_write_addr", 64'(bram_addr), 64'h1fff_ffff);
            end else begin
                e = expq.pop_front();
                chk("write_addr", 64'(bram_addr), 64'(e.a));
                chk("write_data", 64'(bram_wrdata), 64'(e.d));
                if (e.last) irq_pend = 1'b1;
            end
        end
        rst_prev = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_row(input int blk, input int r);
        logic [127:0] c;
        for (int k = 0; k < 8; k++) c[k*16 +: 16] = {blk[3:0], r[7:0], k[3:0]};
        return c;
    endfunction

    task automatic push(input logic [12:0] a, input logic [31:0] d, input bit last);
        exp_t e;
        e.a = a; e.d = d; e.last = last;
        expq.push_back(e);
    endtask

    // Waits (bounded) for wb_ready, queues the first nwords expected writes, strobes the row.
    task automatic send_row(input logic [127:0] coef, input logic [12:0] a0,
                            input int nwords, input bit last);
        int n = 0;
        while (!wb_ready && n < 50) begin tick(); n++; end
        if (!wb_ready) begin
            chk("wb_ready_timeout", 64'(wb_ready), 64'd1);
            return;
        end
        for (int w = 0; w < nwords; w++)
            push(a0 + 13'(w), coef[w*32 +: 32], last && (w == 3));
        dct_valid = 1'b1;
        dct_coef  = coef;
        tick();
        dct_valid = 1'b0;
    endtask

    task automatic start(input logic p);
        wb_start = 1'b1;
        wb_partition = p;
        tick();
        wb_start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 200) begin tick(); n++; end
        chk("drain_queue_left", 64'(expq.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_block(input logic p, input int blk, input logic irq_after);
        logic [12:0] base;
        base = p ? 13'h600 : 13'h400;
        start(p);
        chk("armed_ready", 64'(wb_ready), 64'd1);
        for (int r = 0; r < 128; r++) begin
            if (blk == 0 && r == 0) begin
                push(13'h400, 32'h0001_0000, 1'b0);
                push(13'h401, 32'h0003_0002, 1'b0);
                push(13'h402, 32'h0005_0004, 1'b0);
                push(13'h403, 32'h0007_0006, 1'b0);
                send_row(mk_row(0, 0), base, 0, 1'b0);
                // Now in the first write cycle of the row.
                for (int i = 0; i < 5; i++) begin
                    chk($sformatf("ready_burst_c%0d", i + 1), 64'(wb_ready),
                        (i < 4) ? 64'(SKID) : 64'd1);
                    if (i < 4) tick();
                end
            end else begin
                send_row(mk_row(blk, r), base + 13'(r * 4), 4, r == 127);
            end
        end
        drain();
        tick();
        tick();
        chk("irq_after_block", 64'(ps_irq), 64'(irq_after));
        chk("idle_ready", 64'(wb_ready), 64'd0);
        chk("idle_error", 64'(wb_error), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        tick(); tick();
        rst = 1'b0;
        chk("rst_wb_ready", 64'(wb_ready), 64'd0);
        chk("rst_bram_en", 64'(bram_en), 64'd0);
        chk("rst_bram_we", 64'(bram_we), 64'd0);
        chk("rst_bram_addr", 64'(bram_addr), 64'd0);
        chk("rst_bram_wrdata", 64'(bram_wrdata), 64'd0);
        chk("rst_ps_irq", 64'(ps_irq), 64'd0);
        chk("rst_wb_error", 64'(wb_error), 64'd0);

        // Full partition A (first row is the directed vector), then full partition B.
        run_block(1'b0, 0, 1'b1);
        run_block(1'b1, 1, 1'b0);

        // Dropped rows: one in IDLE, one right after a capture.
        dct_valid = 1'b1; dct_coef = mk_row(9, 9);
        tick();
        dct_valid = 1'b0;
        chk("err_idle_row", 64'(wb_error), 64'd1);
        start(1'b0);
        chk("err_cleared_by_start", 64'(wb_error), 64'd0);
        send_row(mk_row(2, 0), 13'h400, 4, 1'b0);
        if (SKID) push(13'h404, mk_row(2, 1)[31:0], 1'b0);
        if (SKID) push(13'h405, mk_row(2, 1)[63:32], 1'b0);
        if (SKID) push(13'h406, mk_row(2, 1)[95:64], 1'b0);
        if (SKID) push(13'h407, mk_row(2, 1)[127:96], 1'b0);
        dct_valid = 1'b1; dct_coef = mk_row(2, 1);
        tick();
        dct_valid = 1'b0;
        chk("err_busy_row", 64'(wb_error), SKID ? 64'd0 : 64'd1);
        drain();

        // Reset in the second cycle of a write burst.
        do_reset();
        start(1'b0);
        send_row(mk_row(3, 0), 13'h400, 2, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_bram_en", 64'(bram_en), 64'd0);
        chk("midrst_bram_we", 64'(bram_we), 64'd0);
        chk("midrst_bram_addr", 64'(bram_addr), 64'd0);
        chk("midrst_bram_wrdata", 64'(bram_wrdata), 64'd0);
        chk("midrst_wb_ready", 64'(wb_ready), 64'd0);
        chk("midrst_ps_irq", 64'(ps_irq), 64'd0);
        chk("midrst_wb_error", 64'(wb_error), 64'd0);
        rst = 1'b0;
        dct_valid = 1'b1; dct_coef = mk_row(5, 5);
        tick();
        dct_valid = 1'b0;
        tick(); tick();
        chk("after_rst_ready", 64'(wb_ready), 64'd0);
        start(1'b1);
        chk("after_rst_start_err", 64'(wb_error), 64'd0);
        send_row(mk_row(4, 0), 13'h600, 4, 1'b0);
        drain();

`ifdef FBINDCT_WB_SKID_EN
        // Back-to-back rows every 4 cycles keep the write port busy continuously.
        do_reset();
        start(1'b0);
        for (int c = 0; c < 32; c++) begin
            if (c % 4 == 0) begin
                chk($sformatf("skid_ready_r%0d", c / 4), 64'(wb_ready), 64'd1);
                for (int w = 0; w < 4; w++)
                    push(13'h400 + 13'(c + w), mk_row(6, c / 4)[w*32 +: 32], 1'b0);
                dct_valid = 1'b1;
                dct_coef  = mk_row(6, c / 4);
            end else begin
                dct_valid = 1'b0;
            end
            tick();
            dct_valid = 1'b0;
            chk($sformatf("skid_en_c%0d", c), 64'(bram_en), 64'd1);
        end
        chk("skid_wb_error", 64'(wb_error), 64'd0);
        drain();
`endif

        chk("final_queue_empty", 64'(expq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
